ram_port_master: RTL and testbench



---
 rtl/ram_bus_pkg.sv | 13 +
 rtl/ram_rd_return.sv | 34 +++
 rtl/ram_port_master.sv | 114 +++++++++++
 tb/tb_ram_port_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the 24-bit address / 16-bit data RAM request bus.
package ram_bus_pkg;

    localparam int RAM_ADDR_W = 24;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_PEND  = 2'd1,
        WR_FENCE = 2'd2
    } ram_master_state_e;

endpackage

// File: rtl/ram_rd_return.sv
// Read-return path: paced pops of the RAM read-data FIFO and the registered
// response to the processor.
module ram_rd_return
    import ram_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_rd_ready,
    input  logic [RAM_DATA_W-1:0] ram_rd_data,
    input  logic                  pending,
    output logic                  pop,
    output logic                  ram_rd_ack,
    output logic                  resp_valid,
    output logic [RAM_DATA_W-1:0] resp_data
);

    // Skipping the cycle after an ack gives the FIFO head time to advance.
    assign pop = ram_rd_ready && pending && !ram_rd_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rd_ack <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            ram_rd_ack <= pop;
            resp_valid <= pop;
            if (pop) begin
                resp_data <= ram_rd_data;
            end
        end
    end

endmodule

// File: rtl/ram_port_master.sv
// RAM bus initiator: issues single-word strobes, limits outstanding reads,
// fences reads behind writes and returns read words in request order.
module ram_port_master
    import ram_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FENCE_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [RAM_ADDR_W-1:0] req_addr,
    input  logic [RAM_DATA_W-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [RAM_DATA_W-1:0] resp_data,
    output logic [3:0]            outstanding,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [RAM_DATA_W-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    input  logic                  ram_busy,
    input  logic                  ram_rd_ready,
    input  logic [RAM_DATA_W-1:0] ram_rd_data,
    output logic                  ram_rd_ack,
    output logic [1:0]            state_dbg
);

    ram_master_state_e state;
    logic [7:0]        fence_cnt;
    logic [7:0]        fence_next;
    logic [3:0]        out_next;
    logic              strobe_active;
    logic              rd_ok;
    logic              wr_ok;
    logic              wr_accept;
    logic              rd_accept;
    logic              pop;

    assign state_dbg = state;

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; req_we/req_addr/req_wdata are only looked at
    // on that edge. req_ready never depends on state changed by that edge.
    assign strobe_active = ram_wr_en || ram_rd_en;
    assign rd_ok         = (outstanding < 4'(MAX_OUTSTANDING)) && (fence_cnt == 8'd0);
    assign wr_ok         = (outstanding == 4'd0);
    assign req_ready     = !rst && !ram_busy && !strobe_active && (req_we ? wr_ok : rd_ok);
    assign wr_accept     = req_valid && req_ready && req_we;
    assign rd_accept     = req_valid && req_ready && !req_we;

    always_comb begin
        out_next = outstanding;
        if (rd_accept && !pop) begin
            out_next = outstanding + 4'd1;
        end else if (!rd_accept && pop) begin
            out_next = outstanding - 4'd1;
        end
    end

    always_comb begin
        fence_next = 8'd0;
        if (wr_accept) begin
            fence_next = 8'(FENCE_CYCLES);
        end else if (fence_cnt != 8'd0) begin
            fence_next = fence_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fence_cnt   <= 8'd0;
            outstanding <= 4'd0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
        end else begin
            ram_wr_en   <= wr_accept;
            ram_rd_en   <= rd_accept;
            fence_cnt   <= fence_next;
            outstanding <= out_next;
            if (wr_accept || rd_accept) begin
                ram_addr <= req_addr;
            end
            if (wr_accept) begin
                ram_wr_data <= req_wdata;
            end
            // A running fence dominates; otherwise pending reads decide.
            if (fence_next != 8'd0) begin
                state <= WR_FENCE;
            end else if (out_next != 4'd0) begin
                state <= RD_PEND;
            end else begin
                state <= IDLE;
            end
        end
    end

    ram_rd_return u_rd_return (
        .clk          (clk),
        .rst          (rst),
        .ram_rd_ready (ram_rd_ready),
        .ram_rd_data  (ram_rd_data),
        .pending      (outstanding != 4'd0),
        .pop          (pop),
        .ram_rd_ack   (ram_rd_ack),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data)
    );

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: RAM-side model, request-level reference model
// and response scoreboard, directed scenarios plus a randomized run.
module tb_ram_port_master;
  import ram_bus_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int FENCE   = 16;
  localparam int BUDGET  = 400;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [3:0]  outstanding;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic        ram_busy;
  logic        ram_rd_ready;
  logic [15:0] ram_rd_data;
  logic        ram_rd_ack;
  logic [1:0]  state_dbg;

  ram_port_master #(
    .MAX_OUTSTANDING (MAX_OUT),
    .FENCE_CYCLES    (FENCE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .outstanding  (outstanding),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_busy     (ram_busy),
    .ram_rd_ready (ram_rd_ready),
    .ram_rd_data  (ram_rd_data),
    .ram_rd_ack   (ram_rd_ack),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard state ----------------
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } req_t;

  logic [15:0] ref_mem [int];   // memory as the processor sees it, updated at accept
  logic [15:0] ram_mem [int];   // memory inside the RAM model, updated at strobe
  logic [15:0] exp_q [$];       // expected read responses, request order
  logic [15:0] rd_fifo [$];     // RAM read-data FIFO
  logic [15:0] dly_data [$];    // reads in flight inside the RAM
  int          dly_due [$];

  req_t acc_info;
  logic acc_prev     = 1'b0;
  logic ack_exp_next = 1'b0;
  int   model_out    = 0;
  int   last_wr_cyc  = -1000;
  int   last_ack_cyc = -1000;
  int   rd_strobes   = 0;
  logic ram_hold     = 1'b0;
  int   ram_lat_max  = 3;
  logic rand_busy    = 1'b0;

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ram_rd(input int a);
    return ram_mem.exists(a) ? ram_mem[a] : 16'h0000;
  endfunction

  // Monitor + RAM model, sampled mid-cycle.
  always @(negedge clk) begin
    logic        ack_now;
    logic        exp_ready;
    logic [15:0] exp_d;
    if (rst) begin
      acc_prev     = 1'b0;
      ack_exp_next = 1'b0;
      model_out    = 0;
      last_wr_cyc  = -1000;
      last_ack_cyc = -1000;
      exp_q.delete();
      rd_fifo.delete();
      dly_data.delete();
      dly_due.delete();
      ram_rd_ready = 1'b0;
      ram_rd_data  = 16'h0000;
    end else begin
      // strobes appear exactly one cycle after an accept
      check_eq("wr_strobe", 32'(ram_wr_en), 32'(acc_prev && acc_info.we));
      check_eq("rd_strobe", 32'(ram_rd_en), 32'(acc_prev && !acc_info.we));
      if (acc_prev) begin
        check_eq("strobe_addr", 32'(ram_addr), 32'(acc_info.addr));
        if (acc_info.we) begin
          check_eq("strobe_wdata", 32'(ram_wr_data), 32'(acc_info.data));
          last_wr_cyc = cyc;
        end else begin
          rd_strobes++;
          check_eq("fence_gap", 32'((cyc - last_wr_cyc) > FENCE), 32'd1);
        end
      end

      // return path
      ack_now = ack_exp_next;
      check_eq("rd_ack", 32'(ram_rd_ack), 32'(ack_now));
      check_eq("resp_valid", 32'(resp_valid), 32'(ack_now));
      if (ram_rd_ack) begin
        check_eq("ack_spacing", 32'((cyc - last_ack_cyc) >= 2), 32'd1);
        last_ack_cyc = cyc;
      end
      if (ack_now) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check_eq("resp_data", 32'(resp_data), 32'(exp_d));
      end

      model_out = model_out + ((acc_prev && !acc_info.we) ? 1 : 0) - (ack_now ? 1 : 0);
      check_eq("outstanding", 32'(outstanding), 32'(model_out));

      // RAM side
      if (ram_rd_ack && rd_fifo.size() > 0) void'(rd_fifo.pop_front());
      if (ram_wr_en) ram_mem[int'(ram_addr)] = ram_wr_data;
      if (ram_rd_en) begin
        dly_data.push_back(ram_rd(int'(ram_addr)));
        dly_due.push_back(cyc + $urandom_range(1, ram_lat_max));
      end
      while (!ram_hold && dly_due.size() > 0 && dly_due[0] <= cyc) begin
        rd_fifo.push_back(dly_data.pop_front());
        void'(dly_due.pop_front());
      end
      ram_rd_ready = (rd_fifo.size() > 0);
      ram_rd_data  = (rd_fifo.size() > 0) ? rd_fifo[0] : 16'h0000;

      // request side
      if (req_valid) begin
        if (req_we) exp_ready = !ram_busy && !acc_prev && (model_out == 0);
        else        exp_ready = !ram_busy && !acc_prev && (model_out < MAX_OUT) &&
                                ((cyc - last_wr_cyc) >= FENCE);
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      end
      acc_prev = req_valid && req_ready;
      if (acc_prev) begin
        acc_info.we   = req_we;
        acc_info.addr = req_addr;
        acc_info.data = req_wdata;
        if (req_we) ref_mem[int'(req_addr)] = req_wdata;
        else        exp_q.push_back(ref_rd(int'(req_addr)));
      end

      ack_exp_next = ram_rd_ready && (model_out > 0) && !ack_now;
    end
  end

  always @(posedge clk) begin
    if (rand_busy) begin
      #1;
      ram_busy = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic we, input logic [23:0] addr, input logic [15:0] data,
                      output int waits);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    waits     = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits >= BUDGET) begin
        check_eq("req_accept_timeout", 32'(req_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 24'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic send_n(input logic we, input logic [23:0] addr, input logic [15:0] data);
    int w;
    send(we, addr, data, w);
  endtask

  task automatic drain();
    int n = 0;
    while ((model_out != 0 || exp_q.size() != 0) && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq("drain_outstanding", 32'(outstanding), 32'd0);
    check_eq("drain_resp_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(ram_rd_en), 32'd0);
    check_eq({tag, "_rd_ack"}, 32'(ram_rd_ack), 32'd0);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    check_eq({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check_eq({tag, "_ram_wr_data"}, 32'(ram_wr_data), 32'd0);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int base;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    ram_busy  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // write then read of the same word, across the fence
    send(1'b1, 24'h000123, 16'hBEEF, w);
    check_eq("wr_accept_wait", 32'(w), 32'd0);
    check_eq("wr_strobe_now", 32'(ram_wr_en), 32'd1);
    check_eq("state_fence", 32'(state_dbg), 32'(WR_FENCE));
    send(1'b0, 24'h000123, 16'h0000, w);
    check_eq("fence_wait", 32'(w), 32'(FENCE));
    drain();
    check_eq("state_idle", 32'(state_dbg), 32'(IDLE));

    // six back-to-back reads against a stalled RAM
    ram_hold = 1'b1;
    base = rd_strobes;
    fork
      for (int i = 0; i < 6; i++) send_n(1'b0, 24'h000200 + 24'(i), 16'h0000);
      begin
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_strobes", 32'(rd_strobes - base), 32'd4);
        check_eq("b2b_outstanding", 32'(outstanding), 32'(MAX_OUT));
        check_eq("b2b_ready_low", 32'(req_ready), 32'd0);
        check_eq("state_rd_pend", 32'(state_dbg), 32'(RD_PEND));
        ram_hold = 1'b0;
      end
    join
    drain();

    // three returns with ram_rd_ready held high
    for (int i = 0; i < 3; i++) begin
      ref_mem[32'h300 + i] = 16'(i + 1);
      ram_mem[32'h300 + i] = 16'(i + 1);
    end
    ram_hold = 1'b1;
    for (int i = 0; i < 3; i++) send_n(1'b0, 24'h000300 + 24'(i), 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    check_eq("ret3_outstanding", 32'(outstanding), 32'd3);
    ram_hold = 1'b0;
    drain();

    // ram_busy holds off a pending request
    ram_busy = 1'b1;
    base = rd_strobes;
    fork
      send_n(1'b0, 24'h000400, 16'h0000);
      begin
        repeat (5) @(posedge clk);
        #1;
        check_eq("busy_no_strobe", 32'(rd_strobes - base), 32'd0);
        check_eq("busy_ready_low", 32'(req_ready), 32'd0);
        ram_busy = 1'b0;
      end
    join
    drain();

    // write waits for two outstanding reads to return
    ram_hold = 1'b1;
    send_n(1'b0, 24'h000501, 16'h0000);
    send_n(1'b0, 24'h000502, 16'h0000);
    fork
      send(1'b1, 24'h000500, 16'h1234, w);
      begin
        repeat (10) @(posedge clk);
        #1;
        check_eq("wr_held_outstanding", 32'(outstanding), 32'd2);
        check_eq("wr_held_ready", 32'(req_ready), 32'd0);
        ram_hold = 1'b0;
      end
    join
    send_n(1'b0, 24'h000500, 16'h0000);
    drain();

    // spurious read data with nothing outstanding is left alone
    rd_fifo.push_back(16'hDEAD);
    repeat (4) @(posedge clk);
    #1;
    check_eq("spurious_no_ack", 32'(ram_rd_ack), 32'd0);
    rd_fifo.delete();
    @(posedge clk);
    #1;

    // reset with three reads outstanding
    ram_hold = 1'b1;
    for (int i = 0; i < 3; i++) send_n(1'b0, 24'h000600 + 24'(i), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_reads");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ram_hold = 1'b0;

    // reset during a write fence: the next read goes straight out
    send_n(1'b1, 24'h000610, 16'h5A5A);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_fence");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b0, 24'h000611, 16'h0000, w);
    check_eq("post_rst_read_wait", 32'(w), 32'd0);
    drain();

    // randomized traffic with random busy and RAM latency
    ram_lat_max = 6;
    rand_busy   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_n($urandom_range(0, 3) == 0, 24'h000700 + 24'($urandom_range(0, 7)),
             16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_busy = 1'b0;
    @(posedge clk);
    #2;
    ram_busy = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
